// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder BIST: state encoding and vector sizing.
package fa_bist_pkg;
  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/fa_golden.sv
// Golden full-adder response for a vector index {a,b,cin}, derived from the
// parity/majority definition rather than from any adder structure.
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output logic             sum_o,
  output logic             carry_o
);
  always_comb begin
    sum_o   = ^idx_i;
    carry_o = (idx_i[2] & idx_i[1]) | (idx_i[2] & idx_i[0]) | (idx_i[1] & idx_i[0]);
  end
endmodule

// File: rtl/fa_bist.sv
// Exhaustive 8-vector BIST for an external full adder; every output is a flop,
// so dut_sum/dut_carry only ever reach outputs through registered state.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_cin,
  input  logic       dut_sum,
  input  logic       dut_carry,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);
  state_e           state_q;
  logic [IDX_W-1:0] idx_q, ffv_q;
  logic [3:0]       settle_q, err_q, err_d;
  logic             busy_q, done_q, pass_q, fv_q;
  logic             exp_sum, exp_carry, mismatch;

  fa_golden u_golden (
    .idx_i   (idx_q),
    .sum_o   (exp_sum),
    .carry_o (exp_carry)
  );

  assign mismatch = {dut_sum, dut_carry} != {exp_sum, exp_carry};
  assign err_d    = err_q + {3'b000, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ffv_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= APPLY;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            ffv_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        APPLY: begin
          if (settle_q == 4'(SETTLE - 1)) begin
            state_q  <= CHECK;
            settle_q <= '0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        CHECK: begin
          err_q <= err_d;
          if (mismatch && !fv_q) begin
            fv_q  <= 1'b1;
            ffv_q <= idx_q;
          end
          // Last vector parks idx at 7 so DONE keeps driving it.
          if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
          end else begin
            state_q  <= APPLY;
            idx_q    <= idx_q + 1'b1;
            settle_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {dut_a, dut_b, dut_cin} = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;
endmodule

// File: doc/fa_bist.md
FA_BIST -- requirements
Module: fa_bist

Interface
REQ-001 Parameter SETTLE, default 1, range 1..15: cycles each vector is held on the DUT before its response is checked.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to run the full 8-vector test.
REQ-005 dut_a, dut_b, dut_cin  output  1 each  registered stimulus to the external full adder.
REQ-006 dut_sum, dut_carry  input  1 each  response from the external full adder.
REQ-007 busy  output  1  high while a test is running.
REQ-008 done  output  1  high while the completed result is held.
REQ-009 pass  output  1  high with done when err_count is 0.
REQ-010 err_count  output  4  number of mismatching vectors, 0..8.
REQ-011 fail_valid  output  1  high once any mismatch has been recorded in the current run.
REQ-012 first_fail_vec  output  3  index of the first mismatching vector; valid only when fail_valid is high.

Function
REQ-013 The FSM SHALL have the states IDLE, APPLY, CHECK and DONE.
REQ-014 Vector index idx (3 bits, 0..7) SHALL drive {dut_a,dut_b,dut_cin} = idx, with a as MSB; this gives the order 000, 001, ... 111.
REQ-015 In IDLE, start=1 SHALL do four things at the next edge: clear err_count, fail_valid and first_fail_vec; set idx=0; set busy=1; enter APPLY.
REQ-016 APPLY SHALL hold the current vector for exactly SETTLE cycles, counted by a settle counter, then enter CHECK.
REQ-017 CHECK SHALL last one cycle. In it, the block compares {dut_sum,dut_carry} with the golden values for idx, where sum = a^b^cin and carry = majority(a,b,cin).
REQ-018 On a CHECK mismatch, err_count SHALL increment by 1. If fail_valid is 0, first_fail_vec SHALL be set to idx and fail_valid to 1.
REQ-019 CHECK with idx<7 SHALL increment idx and enter APPLY. CHECK with idx=7 SHALL enter DONE without wrapping idx.
REQ-020 Each vector SHALL take SETTLE+1 cycles. If start is sampled at edge 0, done SHALL first be high after edge 8*(SETTLE+1).
REQ-021 In DONE, done=1, busy=0 and pass=(err_count==0). The result SHALL be held indefinitely.
REQ-022 start in DONE SHALL restart the test exactly as from IDLE (REQ-015), and done SHALL drop at that edge.
REQ-023 start while busy (APPLY or CHECK) SHALL be ignored, with no effect on idx, counters or state.
REQ-024 In IDLE, dut_a, dut_b and dut_cin SHALL be 0. In DONE they SHALL hold vector 7.
REQ-025 err_count SHALL never exceed 8 and needs no saturation logic.

Reset
REQ-026 rst=1 SHALL force IDLE at the next edge, from any state, including mid-run. It takes priority over start.
REQ-027 The reset values of all outputs (dut_a, dut_b, dut_cin, busy, done, pass, err_count, fail_valid, first_fail_vec) and of idx and the settle counter SHALL be 0.

Structure
REQ-028 Package fa_bist_pkg SHALL hold the state encoding (IDLE, APPLY, CHECK, DONE), NUM_VECTORS=8 and the index width 3.
REQ-029 Sub-module fa_golden, a behavioural combinational golden model, SHALL compute the expected sum and carry from idx. It SHALL be independent of the DUT implementation.
REQ-030 All stimulus outputs SHALL be driven from flops. There SHALL be no combinational path from dut_sum or dut_carry to any output.

Verification
REQ-031 Correct full adder, SETTLE=1, start pulsed at edge 0 -> done=1 after edge 16, pass=1, err_count=0, fail_valid=0.
REQ-032 DUT with carry stuck-at-0 -> err_count=4, first_fail_vec=3, fail_valid=1, pass=0.
REQ-033 DUT with sum inverted -> err_count=8, first_fail_vec=0, pass=0.
REQ-034 start re-pulsed during APPLY of vector 2 -> no restart, and done still arrives at edge 16.
REQ-035 rst asserted during vector 4 -> the next cycle shows IDLE, with all outputs 0. A new start then gives a clean full run with pass=1.
REQ-036 SETTLE=3, correct DUT -> done after edge 32. Each vector is held stable for 3 APPLY cycles plus 1 CHECK cycle.
